// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: decoupling queue between icache and decode.
// Accepts 2-wide fetch packets, stores only mask-valid slots in program order,
// and presents up to the two oldest instructions to the decoder each cycle.
// Optional feature macro: IFQ_BYPASS_EN (empty-queue same-cycle bypass to out_*).
module inst_fetch_queue #(
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PRED_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [1:0][31:0]       in_insts_i,
    input  logic [31:0]            in_pc_i,
    input  logic [1:0]             in_mask_i,
    input  logic [1:0][PRED_W-1:0] in_pred_i,
    output logic [1:0]             out_valid_o,
    output logic [1:0][31:0]       out_insts_o,
    output logic [1:0][31:0]       out_pc_o,
    output logic [1:0][PRED_W-1:0] out_pred_o,
    input  logic                   out_ready_i
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [AW:0]       r_count;

    logic [31:0]       r_inst [DEPTH];
    logic [31:0]       r_pc   [DEPTH];
    logic [PRED_W-1:0] r_pred [DEPTH];

    logic [31:0]             w_pc_base;
    logic [1:0]              w_cmp_n;
    logic [1:0][31:0]        w_cmp_inst;
    logic [1:0][31:0]        w_cmp_pc;
    logic [1:0][PRED_W-1:0]  w_cmp_pred;
    logic                    w_enq_fire;
    logic                    w_deq_fire;
    logic                    w_bypass;
    logic                    w_wr;
    logic [1:0]              w_n_enq;
    logic [1:0]              w_n_deq;
    logic [AW-1:0]           w_tail_p1;
    logic [AW-1:0]           w_head_p1;
    logic [AW:0]             w_count_next;

    // Low three pc bits are masked rather than sliced so every input bit is consumed.
    assign w_pc_base  = in_pc_i & ~32'h7;
    assign in_ready_o = (r_count <= (AW + 1)'(DEPTH - 2));
    assign w_enq_fire = in_valid_i & in_ready_o;
    assign w_deq_fire = out_ready_i & (|out_valid_o);
    assign w_tail_p1  = r_tail + AW'(1);
    assign w_head_p1  = r_head + AW'(1);

`ifdef IFQ_BYPASS_EN
    assign w_bypass = (r_count == '0) & in_valid_i & ~flush_i;
`else
    assign w_bypass = 1'b0;
`endif

    // Compact the incoming packet so that valid slots occupy positions 0..n-1.
    always_comb begin
        w_cmp_n    = 2'd0;
        w_cmp_inst = '0;
        w_cmp_pc   = '0;
        w_cmp_pred = '0;
        unique case (in_mask_i)
            2'b11: begin
                w_cmp_n       = 2'd2;
                w_cmp_inst[0] = in_insts_i[0];
                w_cmp_pc[0]   = w_pc_base;
                w_cmp_pred[0] = in_pred_i[0];
                w_cmp_inst[1] = in_insts_i[1];
                w_cmp_pc[1]   = w_pc_base + 32'd4;
                w_cmp_pred[1] = in_pred_i[1];
            end
            2'b01: begin
                w_cmp_n       = 2'd1;
                w_cmp_inst[0] = in_insts_i[0];
                w_cmp_pc[0]   = w_pc_base;
                w_cmp_pred[0] = in_pred_i[0];
            end
            2'b10: begin
                w_cmp_n       = 2'd1;
                w_cmp_inst[0] = in_insts_i[1];
                w_cmp_pc[0]   = w_pc_base + 32'd4;
                w_cmp_pred[0] = in_pred_i[1];
            end
            default: w_cmp_n = 2'd0;
        endcase
    end

    // Drive the decoder from the queue head, or from the compacted packet when bypassing.
    always_comb begin
        out_valid_o    = {(r_count >= (AW + 1)'(2)), (r_count >= (AW + 1)'(1))};
        out_insts_o[0] = r_inst[r_head];
        out_insts_o[1] = r_inst[w_head_p1];
        out_pc_o[0]    = r_pc[r_head];
        out_pc_o[1]    = r_pc[w_head_p1];
        out_pred_o[0]  = r_pred[r_head];
        out_pred_o[1]  = r_pred[w_head_p1];
        if (w_bypass) begin
            out_valid_o = (w_cmp_n == 2'd2) ? 2'b11 : ((w_cmp_n == 2'd1) ? 2'b01 : 2'b00);
            out_insts_o = w_cmp_inst;
            out_pc_o    = w_cmp_pc;
            out_pred_o  = w_cmp_pred;
        end
    end

    // Per-cycle enqueue/dequeue amounts; bypassed slots taken by decode never enter storage.
    always_comb begin
        w_n_enq = 2'd0;
        w_n_deq = 2'd0;
        if (w_enq_fire && !(w_bypass && out_ready_i)) begin
            w_n_enq = w_cmp_n;
        end
        if (w_deq_fire && !w_bypass) begin
            w_n_deq = {1'b0, out_valid_o[0]} + {1'b0, out_valid_o[1]};
        end
        w_count_next = r_count + (AW + 1)'(w_n_enq) - (AW + 1)'(w_n_deq);
    end

    assign w_wr = ~rst & ~flush_i & (w_n_enq != 2'd0);

    // Pointer and occupancy state; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(w_n_deq);
            r_tail  <= r_tail + AW'(w_n_enq);
            r_count <= w_count_next;
        end
    end

    // Payload storage; contents are only meaningful between head and tail.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_inst[r_tail] <= w_cmp_inst[0];
            r_pc[r_tail]   <= w_cmp_pc[0];
            r_pred[r_tail] <= w_cmp_pred[0];
            if (w_n_enq == 2'd2) begin
                r_inst[w_tail_p1] <= w_cmp_inst[1];
                r_pc[w_tail_p1]   <= w_cmp_pc[1];
                r_pred[w_tail_p1] <= w_cmp_pred[1];
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed self-checking bench for inst_fetch_queue (DEPTH=16, PRED_W=32).
module tb_inst_fetch_queue;

    logic             clk;
    logic             rst;
    logic             flush_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0][31:0] in_insts_i;
    logic [31:0]      in_pc_i;
    logic [1:0]       in_mask_i;
    logic [1:0][31:0] in_pred_i;
    logic [1:0]       out_valid_o;
    logic [1:0][31:0] out_insts_o;
    logic [1:0][31:0] out_pc_o;
    logic [1:0][31:0] out_pred_o;
    logic             out_ready_i;

    int checks = 0;
    int errors = 0;

    inst_fetch_queue #(.DEPTH(16), .PRED_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_insts_i  (in_insts_i),
        .in_pc_i     (in_pc_i),
        .in_mask_i   (in_mask_i),
        .in_pred_i   (in_pred_i),
        .out_valid_o (out_valid_o),
        .out_insts_o (out_insts_o),
        .out_pc_o    (out_pc_o),
        .out_pred_o  (out_pred_o),
        .out_ready_i (out_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_pkt(input logic [1:0] mask, input logic [31:0] pc,
                             input logic [31:0] i0, input logic [31:0] i1);
        in_valid_i    = 1'b1;
        in_mask_i     = mask;
        in_pc_i       = pc;
        in_insts_i[0] = i0;
        in_insts_i[1] = i1;
        in_pred_i[0]  = i0 ^ 32'h5a5a_0000;
        in_pred_i[1]  = i1 ^ 32'h5a5a_0000;
    endtask

    initial begin
        rst         = 1'b1;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        in_insts_i  = '0;
        in_pc_i     = '0;
        in_mask_i   = 2'b00;
        in_pred_i   = '0;
        out_ready_i = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 4; i++) begin
            step();
            chk("idle_valid", 64'(out_valid_o), 64'h0);
            chk("idle_ready", 64'(in_ready_o), 64'h1);
        end

        // Two-slot packet with misaligned pc
        drive_pkt(2'b11, 32'h1c00_0004, 32'hAAAA_0001, 32'hBBBB_0002);
`ifdef IFQ_BYPASS_EN
        chk("t2_bypass_valid", 64'(out_valid_o), 64'h3);
`else
        chk("t2_nolat_valid", 64'(out_valid_o), 64'h0);
`endif
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        chk("t2_valid", 64'(out_valid_o), 64'h3);
        chk("t2_pc0", 64'(out_pc_o[0]), 64'h1c00_0000);
        chk("t2_pc1", 64'(out_pc_o[1]), 64'h1c00_0004);
        chk("t2_inst0", 64'(out_insts_o[0]), 64'hAAAA_0001);
        chk("t2_inst1", 64'(out_insts_o[1]), 64'hBBBB_0002);
        chk("t2_pred1", 64'(out_pred_o[1]), 64'hE1E1_0002);
        step();
        out_ready_i = 1'b0;
        chk("t2_empty", 64'(out_valid_o), 64'h0);

        // Mask 10 then mask 01, decode stalled
        drive_pkt(2'b10, 32'h0000_0080, 32'hDEAD_DEAD, 32'hCCCC_0003);
        step();
        drive_pkt(2'b01, 32'h0000_0088, 32'hDDDD_0004, 32'hDEAD_BEEF);
        step();
        in_valid_i = 1'b0;
        chk("t3_valid", 64'(out_valid_o), 64'h3);
        chk("t3_inst0", 64'(out_insts_o[0]), 64'hCCCC_0003);
        chk("t3_pc0", 64'(out_pc_o[0]), 64'h84);
        chk("t3_pred0", 64'(out_pred_o[0]), 64'h9696_0003);
        chk("t3_inst1", 64'(out_insts_o[1]), 64'hDDDD_0004);
        chk("t3_pc1", 64'(out_pc_o[1]), 64'h88);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("t3_empty", 64'(out_valid_o), 64'h0);

        // Mask 00 packet is accepted but stores nothing
        drive_pkt(2'b00, 32'h0000_0100, 32'h1111_1111, 32'h2222_2222);
        step();
        in_valid_i = 1'b0;
        chk("t_mask00_valid", 64'(out_valid_o), 64'h0);

        // Fill to DEPTH, then drain across the pointer wrap
        for (int k = 0; k < 8; k++) begin
            drive_pkt(2'b11, 32'h0000_1000 + 32'(8 * k), 32'hA000_0000 + 32'(2 * k),
                      32'hA000_0001 + 32'(2 * k));
            chk("t4_fill_ready", 64'(in_ready_o), 64'h1);
            step();
        end
        // Offered packet while full must be refused
        drive_pkt(2'b11, 32'h0000_7000, 32'hBAD0_0000, 32'hBAD0_0001);
        chk("t4_full_ready", 64'(in_ready_o), 64'h0);
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        chk("t4_full_ready2", 64'(in_ready_o), 64'h0);
        for (int j = 0; j < 8; j++) begin
            chk("t4_drain_valid", 64'(out_valid_o), 64'h3);
            chk("t4_drain_inst0", 64'(out_insts_o[0]), 64'(32'hA000_0000 + 32'(2 * j)));
            chk("t4_drain_inst1", 64'(out_insts_o[1]), 64'(32'hA000_0001 + 32'(2 * j)));
            chk("t4_drain_pc0", 64'(out_pc_o[0]), 64'(32'h0000_1000 + 32'(8 * j)));
            chk("t4_drain_pc1", 64'(out_pc_o[1]), 64'(32'h0000_1004 + 32'(8 * j)));
            if (j == 1) begin
                chk("t4_ready_after_deq", 64'(in_ready_o), 64'h1);
            end
            step();
        end
        out_ready_i = 1'b0;
        chk("t4_drained", 64'(out_valid_o), 64'h0);

        // Flush with a colliding handshake
        for (int k = 0; k < 3; k++) begin
            drive_pkt(2'b11, 32'h0000_3000 + 32'(8 * k), 32'hF000_0000 + 32'(k), 32'hF100_0000);
            step();
        end
        drive_pkt(2'b11, 32'h0000_4000, 32'hF200_0000, 32'hF300_0000);
        flush_i = 1'b1;
        step();
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        chk("t5_valid", 64'(out_valid_o), 64'h0);
        chk("t5_ready", 64'(in_ready_o), 64'h1);
        drive_pkt(2'b11, 32'h0000_2000, 32'h6666_0007, 32'h8888_0008);
        step();
        in_valid_i = 1'b0;
        chk("t5_post_valid", 64'(out_valid_o), 64'h3);
        chk("t5_post_inst0", 64'(out_insts_o[0]), 64'h6666_0007);
        chk("t5_post_inst1", 64'(out_insts_o[1]), 64'h8888_0008);
        chk("t5_post_pc0", 64'(out_pc_o[0]), 64'h2000);
        out_ready_i = 1'b1;
        step();
        out_ready_i = 1'b0;
        chk("t5_empty", 64'(out_valid_o), 64'h0);

        // Reset together with flush
        drive_pkt(2'b01, 32'h0000_5000, 32'h7777_0000, 32'h0);
        step();
        in_valid_i = 1'b0;
        rst        = 1'b1;
        flush_i    = 1'b1;
        step();
        rst     = 1'b0;
        flush_i = 1'b0;
        chk("rstflush_valid", 64'(out_valid_o), 64'h0);
        chk("rstflush_ready", 64'(in_ready_o), 64'h1);

`ifdef IFQ_BYPASS_EN
        // Same-cycle bypass on an empty queue
        drive_pkt(2'b11, 32'h0000_6000, 32'hEEEE_0009, 32'hFFFF_000A);
        out_ready_i = 1'b1;
        chk("t6_valid", 64'(out_valid_o), 64'h3);
        chk("t6_inst0", 64'(out_insts_o[0]), 64'hEEEE_0009);
        chk("t6_inst1", 64'(out_insts_o[1]), 64'hFFFF_000A);
        chk("t6_pc1", 64'(out_pc_o[1]), 64'h6004);
        step();
        drive_pkt(2'b10, 32'h0000_6008, 32'h0, 32'h1234_5678);
        chk("t6_m10_valid", 64'(out_valid_o), 64'h1);
        chk("t6_m10_inst0", 64'(out_insts_o[0]), 64'h1234_5678);
        chk("t6_m10_pc0", 64'(out_pc_o[0]), 64'h600C);
        step();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        chk("t6_count0", 64'(out_valid_o), 64'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
